// File: rtl/dec_pkg.sv
// Shared constants for the sinc3 decimator: default ratio/width, stage count,
// droop-compensation shift amounts and the minimum-width rule.
package dec_pkg;

  localparam int DEF_R   = 512;
  localparam int DEF_W   = 41;
  localparam int CIC_N   = 3;
  localparam int COMP_S1 = 3;
  localparam int COMP_S2 = 4;

  // Smallest datapath width that lets modular combs recover an N-stage
  // integrator output: N*log2(R) growth bits, one sign bit, one input bit.
  function automatic int min_width(input int r, input int n);
    return n * $clog2(r) + 2;
  endfunction

endpackage

// File: rtl/cic_integ.sv
// One enable-gated W-bit accumulator with synchronous reset. Wraps modulo
// 2^W on purpose; the downstream combs cancel the wrap.
module cic_integ #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] acc
);

  // Accumulate the addend on every enabled edge; never saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + add;
    end
  end

endmodule

// File: rtl/cic_dec_512.sv
// Third-order CIC decimator: 1-bit modulator stream in, signed W-bit PCM out,
// one sample per R accepted bits.
// Optional: define DEC_DROOP_COMP_EN to add a 3-tap shift-add droop
// compensation FIR after the combs (one extra clock of latency).
module cic_dec_512
  import dec_pkg::*;
#(
  parameter int R = DEF_R,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  input  logic         in_valid,
  output logic [W-1:0] out,
  output logic         out_valid
);

  localparam int LB = $clog2(R);

  if (W < min_width(R, CIC_N)) begin : g_width_check
    $error("cic_dec_512: W is too small for R");
  end
  if ((R < 4) || ((R & (R - 1)) != 0)) begin : g_ratio_check
    $error("cic_dec_512: R must be a power of two and at least 4");
  end

  logic [W-1:0]  step_val;
  logic [W-1:0]  i1;
  logic [W-1:0]  i2;
  logic [W-1:0]  i3;
  logic [W-1:0]  i1_new;
  logic [W-1:0]  i2_new;
  logic [LB-1:0] phase;
  logic          tick_d;

  // Map the modulator bit to +1 / -1 in W-bit two's complement.
  assign step_val = in ? W'(1) : '1;

  // Each stage adds the freshly updated value of the stage before it.
  assign i1_new = i1 + step_val;
  assign i2_new = i2 + i1_new;

  cic_integ #(.W(W)) u_integ1 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .add (step_val),
    .acc (i1)
  );

  cic_integ #(.W(W)) u_integ2 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .add (i1_new),
    .acc (i2)
  );

  cic_integ #(.W(W)) u_integ3 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .add (i2_new),
    .acc (i3)
  );

  // Count accepted bits; flag the edge that accepts the last bit of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= in_valid && (phase == LB'(R - 1));
      if (in_valid) begin
        phase <= phase + 1'b1;
      end
    end
  end

  logic [W-1:0] dx;
  logic [W-1:0] dc1;
  logic [W-1:0] dc2;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [W-1:0] c3;

  // Three cascaded first differences of the sampled I3, modular arithmetic.
  always_comb begin
    c1 = i3 - dx;
    c2 = c1 - dc1;
    c3 = c2 - dc2;
  end

  // Comb delay lines advance only on decimation ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx  <= '0;
      dc1 <= '0;
      dc2 <= '0;
    end else if (tick_d) begin
      dx  <= i3;
      dc1 <= c1;
      dc2 <= c2;
    end
  end

`ifdef DEC_DROOP_COMP_EN

  logic [W-1:0] c_q;
  logic         c_valid;
  logic [W-1:0] f1;
  logic [W-1:0] f2;
  logic [W-1:0] z;

  // Symmetric 3-tap FIR: center tap 1 + 1/8, outer taps -1/16.
  always_comb begin
    z = f1
      + W'($signed(f1) >>> COMP_S1)
      - W'($signed(c_q) >>> COMP_S2)
      - W'($signed(f2) >>> COMP_S2);
  end

  // Hold the comb result one cycle, then filter it and shift the FIR history.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      c_valid   <= 1'b0;
      f1        <= '0;
      f2        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      c_valid   <= tick_d;
      out_valid <= c_valid;
      if (tick_d) begin
        c_q <= c3;
      end
      if (c_valid) begin
        out <= z;
        f1  <= c_q;
        f2  <= f1;
      end
    end
  end

`else

  // Register the raw comb result with a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick_d;
      if (tick_d) begin
        out <= c3;
      end
    end
  end

`endif

endmodule

// File: tb/tb_cic_dec_512.sv
// Self-checking bench for cic_dec_512. The reference computes each output as
// the sinc3 impulse response (three length-R boxcars convolved) applied to the
// accepted +/-1 history, then optionally the droop FIR.
module tb_cic_dec_512;
  import dec_pkg::*;

  localparam int R  = 512;
  localparam int W  = 41;
  localparam int HL = 3 * R - 2;
`ifdef DEC_DROOP_COMP_EN
  localparam int LAT = 2;
  localparam bit DROOP = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit DROOP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;

  cic_dec_512 #(.R(R), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .out       (dout),
    .out_valid (dout_valid)
  );

  always #5 clk = ~clk;

  longint h[HL];
  int     hist[$];
  int     nacc;
  longint fx1, fx2;
  longint pend_val[$];
  int     pend_due[$];
  longint hold;
  int     cyc;
  int     strobes[$];
  longint outs[$];
  int     vectors;
  int     miscompares;

  function automatic longint sinc3_out();
    longint s = 0;
    int n = hist.size();
    for (int j = 0; j < n; j++) s += h[j] * longint'(hist[n-1-j]);
    return s;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare both outputs.
  task automatic step(input logic v, input logic b, input logic r);
    longint x, y;
    logic exp_v;
    rst = r; in_valid = v; din = b;
    @(posedge clk);
    cyc++;
    #1;
    if (r) begin
      hist.delete(); pend_val.delete(); pend_due.delete();
      nacc = 0; fx1 = 0; fx2 = 0; hold = 0;
    end else if (v) begin
      hist.push_back(b ? 1 : -1);
      if (hist.size() > HL) void'(hist.pop_front());
      nacc++;
      if (nacc % R == 0) begin
        x = sinc3_out();
        if (DROOP) begin
          y = fx1 + (fx1 >>> COMP_S1) - (x >>> COMP_S2) - (fx2 >>> COMP_S2);
          fx2 = fx1; fx1 = x;
        end else begin
          y = x;
        end
        pend_val.push_back(y);
        pend_due.push_back(cyc + LAT);
      end
    end
    exp_v = (pend_due.size() > 0) && (pend_due[0] == cyc);
    if (exp_v) begin
      hold = pend_val.pop_front();
      void'(pend_due.pop_front());
    end
    vectors++;
    assert (dout_valid === exp_v) else begin
      miscompares++;
      $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, dout_valid, exp_v);
    end
    vectors++;
    assert (dout === W'(hold)) else begin
      miscompares++;
      $error("FAIL out cyc=%0d observed=%0d expected=%0d", cyc, $signed(dout), hold);
    end
    if (dout_valid) begin
      strobes.push_back(cyc);
      outs.push_back(longint'($signed(dout)));
    end
  endtask

  // mode: 0 ones, 1 zeros, 2 alternating 1/0, 3 ones every other cycle, else random
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: step(1'b1, 1'b1, 1'b0);
        1: step(1'b1, 1'b0, 1'b0);
        2: step(1'b1, 1'(i % 2 == 0), 1'b0);
        3: step(1'(i % 2 == 0), 1'b1, 1'b0);
        default: step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'b0);
      endcase
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(1)), 1'b1);
    strobes.delete();
    outs.delete();
  endtask

  initial begin
    longint h2[2*R-1];
    int start;
    vectors = 0; miscompares = 0; cyc = 0; nacc = 0;
    fx1 = 0; fx2 = 0; hold = 0;

    for (int j = 0; j < 2*R-1; j++) h2[j] = (j + 1 < 2*R - 1 - j) ? j + 1 : 2*R - 1 - j;
    for (int j = 0; j < HL; j++) begin
      h[j] = 0;
      for (int k = (j - R + 1 > 0 ? j - R + 1 : 0); k <= j && k < 2*R-1; k++) h[j] += h2[k];
    end

    // Reset held with toggling input; outputs must stay zero.
    do_reset(5);

    // Constant ones from reset.
    start = cyc;
    run_cycles(6*R + LAT, 0);
    check("ones_count", outs.size(), 6);
    check("ones_first_strobe", strobes[0], start + R + LAT);
    for (int k = 1; k < 6; k++) check("ones_spacing", strobes[k] - strobes[k-1], R);
`ifndef DEC_DROOP_COMP_EN
    check("ones_out1", outs[0], 22500864);
    check("ones_out2", outs[1], 111979008);
    check("ones_out3", outs[2], 134217728);
`endif
    for (int k = 4; k < 6; k++) check("ones_settled", outs[k], 134217728);

    // Keep going until I3 has wrapped; output must not move.
    run_cycles(34*R, 0);
    check("wrap_count", outs.size(), 40);
    for (int k = 4; k < 40; k++) check("wrap_settled", outs[k], 134217728);

    // Constant zeros.
    do_reset(2);
    run_cycles(6*R + LAT, 1);
    check("zeros_count", outs.size(), 6);
    for (int k = 4; k < 6; k++) check("zeros_settled", outs[k], -134217728);

    // Alternating 1/0.
    do_reset(2);
    run_cycles(6*R + LAT, 2);
    check("alt_count", outs.size(), 6);
    for (int k = 4; k < 6; k++) check("alt_settled", outs[k], 0);

    // Ones accepted every other cycle.
    do_reset(2);
    run_cycles(12*R + 2*LAT, 3);
    check("gap_count", outs.size(), 6);
    for (int k = 1; k < 6; k++) check("gap_spacing", strobes[k] - strobes[k-1], 2*R);
`ifndef DEC_DROOP_COMP_EN
    check("gap_out1", outs[0], 22500864);
`endif
    for (int k = 4; k < 6; k++) check("gap_settled", outs[k], 134217728);

    // Reset after 300 accepted bits discards the partial frame.
    do_reset(2);
    run_cycles(300, 0);
    do_reset(1);
    start = cyc;
    run_cycles(R + LAT + 2, 0);
    check("midrst_count", outs.size(), 1);
    check("midrst_strobe", strobes[0], start + R + LAT);
`ifdef DEC_DROOP_COMP_EN
    check("midrst_out1", outs[0], -1406304);
`else
    check("midrst_out1", outs[0], 22500864);
`endif

    // Random bits with random gaps, checked cycle by cycle against the model.
    do_reset(2);
    run_cycles(7*R, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
